// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// div_issue_ctrl : issues div/mod requests to the 32-bit iterative divider and
//                  returns the selected quotient/remainder via valid/ready.
// Revision 1.0
// ============================================================================
module div_issue_ctrl #(
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              op_signed_i,
   input  logic              op_mod_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] result_o,
   output logic              err_o,
   output logic              div_en_o,
   output logic              div_signed_o,
   output logic [DATA_W-1:0] div_dividend_o,
   output logic [DATA_W-1:0] div_divisor_o,
   input  logic [DATA_W-1:0] div_quot_i,
   input  logic [DATA_W-1:0] div_rem_i,
   input  logic              div_fin_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DONE  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam int              WD_W      = $clog2(MAX_WAIT + 1);
   localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(MAX_WAIT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WD_W-1:0]   r_wd;
   logic              r_err;
   logic              r_signed;
   logic              r_mod;
   logic [DATA_W-1:0] r_dividend;
   logic [DATA_W-1:0] r_divisor;
   logic [DATA_W-1:0] r_result;

   logic w_ready_core;
   logic w_accept;
   logic w_div_zero;
   logic w_wd_expired;
   logic w_capture;
   logic w_err_set;
   logic w_in_div;

   // rst is kept out of the accept path so it only ever acts as an async reset.
   assign w_ready_core = (r_state == S_IDLE) & ~flush_i & ~r_err;
   assign w_accept     = in_valid_i & w_ready_core;
   assign w_div_zero   = (divisor_i == '0);
   assign w_wd_expired = (r_wd == c_WD_LAST);
   assign w_in_div     = (r_state == S_BUSY) | (r_state == S_DRAIN);

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_div_zero ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (div_fin_i) begin
               w_state_nxt = flush_i ? S_IDLE : S_DONE;
               w_capture   = ~flush_i;
            end else if (flush_i) begin
               w_state_nxt = S_DRAIN;
            end else if (w_wd_expired) begin
               w_state_nxt = S_IDLE;
               w_err_set   = 1'b1;
            end
         end
         S_DRAIN: begin
            if (div_fin_i) begin
               w_state_nxt = S_IDLE;
            end else if (w_wd_expired) begin
               w_state_nxt = S_IDLE;
               w_err_set   = 1'b1;
            end
         end
         S_DONE: begin
            if (flush_i | out_ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Watchdog restarts on every entry into BUSY or DRAIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd <= '0;
      end else if (w_in_div && (w_state_nxt == r_state)) begin
         r_wd <= r_wd + WD_W'(1);
      end else begin
         r_wd <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_signed   <= 1'b0;
         r_mod      <= 1'b0;
         r_dividend <= '0;
         r_divisor  <= '0;
      end else if (w_accept) begin
         r_signed   <= op_signed_i;
         r_mod      <= op_mod_i;
         r_dividend <= dividend_i;
         r_divisor  <= divisor_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
      end else if (w_accept && w_div_zero) begin
         r_result <= op_mod_i ? dividend_i : '1;
      end else if (w_capture) begin
         r_result <= r_mod ? div_rem_i : div_quot_i;
      end
   end

   assign in_ready_o     = w_ready_core & ~rst;
   assign out_valid_o    = (r_state == S_DONE);
   assign result_o       = r_result;
   assign err_o          = r_err;
   assign div_en_o       = w_in_div;
   assign div_signed_o   = r_signed;
   assign div_dividend_o = r_dividend;
   assign div_divisor_o  = r_divisor;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_div_issue_ctrl : directed + randomized bench with transaction-level model.
// Revision 1.0
// ============================================================================
module tb_div_issue_ctrl;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 40;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid_i = 1'b0;
   logic              in_ready_o;
   logic              op_signed_i = 1'b0;
   logic              op_mod_i = 1'b0;
   logic [DATA_W-1:0] dividend_i = '0;
   logic [DATA_W-1:0] divisor_i = '0;
   logic              flush_i = 1'b0;
   logic              out_valid_o;
   logic              out_ready_i = 1'b0;
   logic [DATA_W-1:0] result_o;
   logic              err_o;
   logic              div_en_o;
   logic              div_signed_o;
   logic [DATA_W-1:0] div_dividend_o;
   logic [DATA_W-1:0] div_divisor_o;
   logic [DATA_W-1:0] div_quot_i;
   logic [DATA_W-1:0] div_rem_i;
   logic              div_fin_i;

   div_issue_ctrl #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .op_signed_i(op_signed_i), .op_mod_i(op_mod_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i),
      .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .result_o(result_o), .err_o(err_o),
      .div_en_o(div_en_o), .div_signed_o(div_signed_o),
      .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
      .div_quot_i(div_quot_i), .div_rem_i(div_rem_i), .div_fin_i(div_fin_i)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t_acc   = 0;
   int en_seen = 0;
   int vld_seen = 0;
   logic fin_dead = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sg, input logic md);
      logic [31:0] q, r;
      int sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (!sg) begin
         q = a / b; r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = 32'd0;
      end else begin
         sa = a; sb = b;
         q = sa / sb; r = sa % sb;
      end
      return md ? r : q;
   endfunction

   // Divider stand-in: 32 enabled cycles, finished on the 33rd, then wraps.
   int r_cnt = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) r_cnt <= 0;
      else if (div_en_o) r_cnt <= (r_cnt == 32) ? 0 : r_cnt + 1;
   end
   assign div_fin_i  = div_en_o && (r_cnt == 32) && !fin_dead;
   assign div_quot_i = ref_div(div_dividend_o, div_divisor_o, div_signed_o, 1'b0);
   assign div_rem_i  = ref_div(div_dividend_o, div_divisor_o, div_signed_o, 1'b1);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: one operation in flight, a pending result, sticky error.
   logic        m_busy = 0, m_keep = 0, m_valid = 0, m_err = 0;
   int          m_wait = 0;
   logic [31:0] m_res = 0, m_a = 0, m_b = 0;
   logic        m_sg = 0, m_md = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_keep <= 0; m_valid <= 0; m_err <= 0; m_wait <= 0;
         m_res <= 0; m_a <= 0; m_b <= 0; m_sg <= 0; m_md <= 0;
      end else if (m_valid) begin
         if (flush_i || out_ready_i) m_valid <= 0;
      end else if (m_busy) begin
         if (div_fin_i) begin
            m_busy <= 0;
            if (m_keep && !flush_i) begin
               m_valid <= 1;
               m_res   <= ref_div(m_a, m_b, m_sg, m_md);
            end
         end else if (m_keep && flush_i) begin
            m_keep <= 0;
            m_wait <= 0;
         end else begin
            m_wait <= m_wait + 1;
            if (m_wait + 1 == MAX_WAIT) begin
               m_err  <= 1;
               m_busy <= 0;
            end
         end
      end else if (in_valid_i && !m_err && !flush_i) begin
         if (divisor_i == 0) begin
            m_valid <= 1;
            m_res   <= op_mod_i ? dividend_i : 32'hFFFF_FFFF;
         end else begin
            m_busy <= 1; m_keep <= 1; m_wait <= 0;
            m_a <= dividend_i; m_b <= divisor_i; m_sg <= op_signed_i; m_md <= op_mod_i;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (div_en_o) en_seen++;
         if (out_valid_o) vld_seen++;
         chk("in_ready", 32'(in_ready_o), 32'(!m_busy && !m_valid && !m_err && !flush_i));
         chk("div_en", 32'(div_en_o), 32'(m_busy));
         chk("out_valid", 32'(out_valid_o), 32'(m_valid));
         chk("err", 32'(err_o), 32'(m_err));
         if (m_busy) begin
            chk("div_dividend", div_dividend_o, m_a);
            chk("div_divisor", div_divisor_o, m_b);
            chk("div_signed", 32'(div_signed_o), 32'(m_sg));
         end
         if (m_valid) chk("result", result_o, m_res);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                            input logic sg, input logic md);
      bit ok = 0;
      in_valid_i = 1; dividend_i = a; divisor_i = b; op_signed_i = sg; op_mod_i = md;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready_o) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      t_acc = cyc;
      step();
      in_valid_i = 0;
   endtask

   task automatic wait_valid(output int lat);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid_o) begin ok = 1; break; end
      end
      if (!ok) chk("valid_timeout", 32'd0, 32'd1);
      lat = cyc - t_acc;
   endtask

   task automatic consume();
      step();
      out_ready_i = 1;
      @(negedge clk);
      chk("no_accept_in_done", 32'(in_ready_o), 32'd0);
      step();
      out_ready_i = 0;
   endtask

   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic md, input logic [31:0] exp,
                         input int exp_lat);
      int lat;
      drive_req(a, b, sg, md);
      wait_valid(lat);
      chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({nm, "_res"}, result_o, exp);
      consume();
   endtask

   initial begin
      int lat, en0, vld0;
      bit ok;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_div_en", 32'(div_en_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_dividend", div_dividend_o, 32'd0);
      rst = 0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready_o), 32'd1);
      step();

      run_op("u100_7_q", 32'd100, 32'd7, 0, 0, 32'd14, 34);
      run_op("u100_7_r", 32'd100, 32'd7, 0, 1, 32'd2, 34);
      run_op("s-7_2_q", 32'hFFFF_FFF9, 32'd2, 1, 0, 32'hFFFF_FFFD, 34);
      run_op("s-7_2_r", 32'hFFFF_FFF9, 32'd2, 1, 1, 32'hFFFF_FFFF, 34);

      en0 = en_seen;
      run_op("dz_q", 32'd5, 32'd0, 0, 0, 32'hFFFF_FFFF, 1);
      run_op("dz_r", 32'd5, 32'd0, 1, 1, 32'd5, 1);
      chk("dz_no_div_en", 32'(en_seen - en0), 32'd0);

      en0 = en_seen; vld0 = vld_seen;
      drive_req(32'd1000, 32'd3, 0, 0);
      repeat (9) step();
      flush_i = 1;
      step();
      flush_i = 0;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!div_en_o) begin ok = 1; break; end
      end
      if (!ok) chk("drain_timeout", 32'd0, 32'd1);
      chk("flush_en_cycles", 32'(en_seen - en0), 32'd33);
      chk("flush_no_valid", 32'(vld_seen - vld0), 32'd0);
      chk("flush_idle_ready", 32'(in_ready_o), 32'd1);
      step();
      run_op("after_flush", 32'd9, 32'd3, 0, 0, 32'd3, 34);

      drive_req(32'd1000, 32'd10, 0, 0);
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         chk("hold_valid", 32'(out_valid_o), 32'd1);
         chk("hold_result", result_o, 32'd100);
      end
      consume();
      run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000, 34);
      run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 0, 0, 32'hFFFF_FFFF, 34);

      fin_dead = 1;
      drive_req(32'd50, 32'd5, 0, 0);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (err_o) begin ok = 1; break; end
      end
      if (!ok) chk("wd_timeout", 32'd0, 32'd1);
      chk("wd_lat", 32'(cyc - t_acc), 32'(MAX_WAIT + 1));
      step();
      in_valid_i = 1; divisor_i = 32'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("err_blocks_ready", 32'(in_ready_o), 32'd0);
         chk("err_no_valid", 32'(out_valid_o), 32'd0);
         step();
      end
      in_valid_i = 0;
      rst = 1;
      step();
      fin_dead = 0;
      rst = 0;
      #1;
      chk("err_cleared", 32'(err_o), 32'd0);
      step();

      drive_req(32'd77, 32'd7, 1, 0);
      repeat (5) step();
      rst = 1;
      #1;
      chk("mid_rst_div_en", 32'(div_en_o), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("mid_rst_result", result_o, 32'd0);
      chk("mid_rst_dividend", div_dividend_o, 32'd0);
      chk("mid_rst_divisor", div_divisor_o, 32'd0);
      chk("mid_rst_signed", 32'(div_signed_o), 32'd0);
      step();
      rst = 0;
      step();

      for (int i = 0; i < 4000; i++) begin
         in_valid_i  = ($urandom % 3) != 0;
         op_signed_i = $urandom % 2;
         op_mod_i    = $urandom % 2;
         case ($urandom % 4)
            0:       dividend_i = 32'h8000_0000;
            1:       dividend_i = $urandom % 256;
            default: dividend_i = $urandom;
         endcase
         case ($urandom % 8)
            0:       divisor_i = 32'd0;
            1:       divisor_i = 32'd1;
            2:       divisor_i = 32'hFFFF_FFFF;
            3:       divisor_i = $urandom % 16;
            4:       divisor_i = 32'd0 - ($urandom % 16);
            default: divisor_i = $urandom;
         endcase
         out_ready_i = ($urandom % 4) != 0;
         flush_i     = ($urandom % 40) == 0;
         step();
      end
      in_valid_i = 0; flush_i = 0; out_ready_i = 1;
      repeat (60) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
